wrap_counter: RTL and testbench



---
 rtl/wrap_counter.sv | 55 +++++
 tb/tb_wrap_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wrap_counter.sv
// Up/down counter with a programmable terminal value: wraps to 0 counting up,
// reloads the terminal value counting down. Sequencing building block for the IO module.
module wrap_counter #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned MAX_WIDTH = 2
) (
  output logic [WIDTH-1:0]     Count,
  input  logic                 Enable,
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [MAX_WIDTH-1:0] Max_Value,
  input  logic                 Up
);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] count_d, count_q;

  // Terminal value resized to the count width: truncate when wider, zero-extend when narrower.
  generate
    if (MAX_WIDTH > WIDTH) begin : g_trunc
      logic unused_max_hi;
      assign unused_max_hi = |Max_Value[MAX_WIDTH-1:WIDTH];
      assign m = Max_Value[WIDTH-1:0];
    end else if (MAX_WIDTH == WIDTH) begin : g_same
      assign m = Max_Value;
    end else begin : g_ext
      assign m = {{(WIDTH - MAX_WIDTH){1'b0}}, Max_Value};
    end
  endgenerate

  // Up: '>=' also recovers when M drops below the count. Down: '>' clamps to M.
  always_comb begin
    count_d = count_q;
    if (Enable) begin
      if (Up) begin
        count_d = (count_q >= m) ? '0 : count_q + WIDTH'(1);
      end else if ((count_q == '0) || (count_q > m)) begin
        count_d = m;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_wrap_counter.sv
// Bench for wrap_counter: directed sequences on several widths, then random stimulus
// against an arithmetic reference model, including async reset pulses.
module tb_wrap_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic [1:0]  max0;
  logic [2:0]  max1;
  logic [7:0]  max2;
  logic [4:0]  max3;
  logic [1:0]  cnt0;
  logic [3:0]  cnt1;
  logic [63:0] cnt2;
  logic [2:0]  cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  wrap_counter #(.WIDTH(2), .MAX_WIDTH(2)) u_dut0 (
    .Count(cnt0), .Enable(en), .CLK(clk), .RST(rst), .Max_Value(max0), .Up(up)
  );
  wrap_counter #(.WIDTH(4), .MAX_WIDTH(3)) u_dut1 (
    .Count(cnt1), .Enable(en), .CLK(clk), .RST(rst), .Max_Value(max1), .Up(up)
  );
  wrap_counter #(.WIDTH(64), .MAX_WIDTH(8)) u_dut2 (
    .Count(cnt2), .Enable(en), .CLK(clk), .RST(rst), .Max_Value(max2), .Up(up)
  );
  wrap_counter #(.WIDTH(3), .MAX_WIDTH(5)) u_dut3 (
    .Count(cnt3), .Enable(en), .CLK(clk), .RST(rst), .Max_Value(max3), .Up(up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [63:0] width_mask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: next count from the rules, with M = terminal value reduced to the count width.
  function automatic logic [63:0] ref_next(input logic [63:0] c, input logic [63:0] raw_max,
                                           input int w, input bit e, input bit u);
    logic [63:0] m;
    m = raw_max & width_mask(w);
    if (!e) return c;
    if (u) return (c >= m) ? 64'd0 : ((c + 64'd1) & width_mask(w));
    if (c == 64'd0 || c > m) return m;
    return c - 64'd1;
  endfunction

  int          widths[4] = '{2, 4, 64, 3};
  logic [63:0] mdl[4];
  logic [63:0] raw[4];
  logic [63:0] got[4];
  logic [1:0]  exp_up[6]   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [3:0]  exp_down[7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
  logic [63:0] exp_low[6]  = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd0};

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1;
    max0 = '0; max1 = '0; max2 = '0; max3 = '0;
    #2;
    check_eq("reset_cnt0", 64'(cnt0), 64'd0);
    check_eq("reset_cnt1", 64'(cnt1), 64'd0);
    check_eq("reset_cnt2", cnt2, 64'd0);
    check_eq("reset_cnt3", 64'(cnt3), 64'd0);
    tick();
    rst = 1'b1;

    // Up wrap, M = 3
    do_reset();
    max0 = 2'd3; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("up_wrap[%0d]", i), 64'(cnt0), 64'(exp_up[i]));
    end

    // Enable gated off once the count reaches 2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      en = (cnt0 != 2'd2);
      tick();
      check_eq($sformatf("en_gate[%0d]", i), 64'(cnt0), (i < 1) ? 64'd1 : 64'd2);
    end

    // Half-word toggle with one held cycle
    do_reset();
    max0 = 2'd1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("toggle[%0d]", i), 64'(cnt0), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    en = 1'b0;
    tick();
    check_eq("toggle_hold", 64'(cnt0), 64'd0);
    en = 1'b1;
    tick();
    check_eq("toggle_resume", 64'(cnt0), 64'd1);

    // Down mode on the 4-bit counter, M = 5
    do_reset();
    max1 = 3'd5; up = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("down[%0d]", i), 64'(cnt1), 64'(exp_down[i]));
    end

    // 64-bit: count to 10, lower M to 4, then M = 0 in both directions
    do_reset();
    max2 = 8'd200; up = 1'b1; en = 1'b1;
    repeat (10) tick();
    check_eq("wide_to10", cnt2, 64'd10);
    max2 = 8'd4;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("wide_lowered[%0d]", i), cnt2, exp_low[i]);
    end
    max2 = 8'd0;
    tick();
    check_eq("wide_m0_up", cnt2, 64'd0);
    up = 1'b0;
    tick();
    check_eq("wide_m0_down", cnt2, 64'd0);

    // Asynchronous reset between edges
    do_reset();
    max0 = 2'd3; up = 1'b1; en = 1'b1;
    tick();
    tick();
    check_eq("arst_pre", 64'(cnt0), 64'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_immediate", 64'(cnt0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("arst_hold[%0d]", i), 64'(cnt0), 64'd0);
    end
    rst = 1'b1;
    tick();
    check_eq("arst_restart", 64'(cnt0), 64'd1);

    // Random stimulus against the reference model
    do_reset();
    for (int k = 0; k < 4; k++) mdl[k] = '0;
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) == 1;
      raw[0] = 64'($urandom_range(0, 3));
      raw[1] = 64'($urandom_range(0, 7));
      raw[2] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255))
                                           : 64'($urandom_range(0, 12));
      raw[3] = 64'($urandom_range(0, 31));
      max0 = raw[0][1:0];
      max1 = raw[1][2:0];
      max2 = raw[2][7:0];
      max3 = raw[3][4:0];
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        got = '{64'(cnt0), 64'(cnt1), cnt2, 64'(cnt3)};
        for (int k = 0; k < 4; k++) check_eq($sformatf("rand_rst[%0d]", k), got[k], 64'd0);
        rst = 1'b1;
      end
      for (int k = 0; k < 4; k++) mdl[k] = ref_next(mdl[k], raw[k], widths[k], en, up);
      tick();
      got = '{64'(cnt0), 64'(cnt1), cnt2, 64'(cnt3)};
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("rand[%0d] dut%0d", n, k), got[k], mdl[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
